// File: rtl/rr_grant_idx.sv
// Round-robin arbiter that emits the binary index of the granted requester
// over a valid/ready handshake. The index feeds a downstream decoder, so it is
// registered and held stable for the whole offer. The offer is sticky: a
// requester dropping its request mid-offer does not withdraw the grant.
//
// Priority: ptr holds the highest-priority index. After each accepted grant,
// ptr moves to grant_idx+1, so the just-served requester becomes lowest
// priority and a continuously requesting input waits at most REQ_BITS-1 grants.
//
// Legal parameters: 2 <= REQ_BITS <= 2**IDX_BITS.
module rr_grant_idx #(
  parameter int unsigned REQ_BITS = 16,
  parameter int unsigned IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REQ_BITS-1:0] req_in,
  output logic                grant_valid,
  input  logic                grant_ready,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                busy
);

  // Two encodings are unused on purpose; they fall back to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StOffer = 2'b01
  } state_e;

  localparam logic [IDX_BITS-1:0] LastIdx = IDX_BITS'(REQ_BITS - 1);

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q;
  logic [IDX_BITS-1:0] grant_idx_q;

  logic                handshake;
  logic [IDX_BITS-1:0] ptr_inc;
  logic [IDX_BITS-1:0] search_base;
  logic [REQ_BITS-1:0] upper_mask;
  logic [REQ_BITS-1:0] masked_req;
  logic                any_req;
  logic [IDX_BITS-1:0] pick_idx;
  logic                load_grant;

  // Index of the lowest set bit of v; zero when v is empty (caller gates on any_req).
  function automatic logic [IDX_BITS-1:0] lowest_set(input logic [REQ_BITS-1:0] v);
    logic [IDX_BITS-1:0] res;
    res = '0;
    for (int i = int'(REQ_BITS) - 1; i >= 0; i--) begin
      if (v[i]) begin
        res = IDX_BITS'(i);
      end
    end
    return res;
  endfunction

  // Handshake only counts while an offer is actually outstanding.
  assign handshake = (state_q == StOffer) && grant_ready;

  // Explicit wrap so a non-power-of-two requester count never yields an
  // out-of-range index.
  assign ptr_inc = (grant_idx_q == LastIdx) ? '0 : grant_idx_q + IDX_BITS'(1);

  // While offering, the search for the next grant must use the pointer that
  // the current handshake is about to install; in idle the stored ptr is live.
  assign search_base = (state_q == StOffer) ? ptr_inc : ptr_q;

  // Rotating priority search: first set bit at or above search_base, else
  // wrap around and take the first set bit from index 0.
  always_comb begin
    upper_mask = '0;
    for (int unsigned i = 0; i < REQ_BITS; i++) begin
      upper_mask[i] = (i >= 32'(search_base));
    end
    masked_req = req_in & upper_mask;
    any_req    = |req_in;
    if (|masked_req) begin
      pick_idx = lowest_set(masked_req);
    end else begin
      pick_idx = lowest_set(req_in);
    end
  end

  // A new index is latched on entry to an offer and on each back-to-back grant.
  assign load_grant = any_req && ((state_q == StIdle) || handshake);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle: begin
        state_d = any_req ? StOffer : StIdle;
      end
      StOffer: begin
        if (handshake) begin
          state_d = any_req ? StOffer : StIdle;
        end else begin
          state_d = StOffer;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Priority pointer advances only on an accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (handshake) begin
      ptr_q <= ptr_inc;
    end
  end

  // Granted index register; held untouched for the whole offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_idx_q <= '0;
    end else if (load_grant) begin
      grant_idx_q <= pick_idx;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    grant_valid = (state_q == StOffer);
    busy        = (state_q == StOffer);
    grant_idx   = grant_idx_q;
  end

  // Offered index must always address a real requester.
  a_idx_in_range : assert property (@(posedge clk) disable iff (rst)
    grant_valid |-> (32'(grant_idx) < REQ_BITS));

  // A pending offer stays up with the same index until accepted.
  a_offer_stable : assert property (@(posedge clk) disable iff (rst)
    (grant_valid && !grant_ready) |=> (grant_valid && $stable(grant_idx)));

endmodule

// File: tb/tb_rr_grant_idx.sv
// Self-checking bench for rr_grant_idx: a 16-requester instance for the main
// scenarios and a 10-requester instance for the non-power-of-two case.
module tb_rr_grant_idx;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        ready;
  logic        valid;
  logic [3:0]  idx;
  logic        busy;

  logic [9:0]  req10;
  logic        ready10;
  logic        valid10;
  logic [3:0]  idx10;
  logic        busy10;

  int tests;
  int fails;
  int exp_q[$];

  rr_grant_idx #(.REQ_BITS(16), .IDX_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req),
    .grant_valid(valid),
    .grant_ready(ready),
    .grant_idx  (idx),
    .busy       (busy)
  );

  rr_grant_idx #(.REQ_BITS(10), .IDX_BITS(4)) dut10 (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req10),
    .grant_valid(valid10),
    .grant_ready(ready10),
    .grant_idx  (idx10),
    .busy       (busy10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Stimulus only: one-cycle synchronous-looking reset pulse, inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; ready = 1'b0; req10 = '0; ready10 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; ready = 1'b0; req10 = '0; ready10 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
    tests++; if (idx !== 4'd0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", idx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    req = 16'h0100;
    @(negedge clk);
    tests++;
    if ({valid, idx} !== {1'b1, 4'd8}) begin
      fails++; $display("FAIL first_offer: got valid=%b idx=%0d expected valid=1 idx=8", valid, idx);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    // Single requester is regranted back-to-back; ptr is now 9.
    tests++;
    if ({valid, idx} !== {1'b1, 4'd8}) begin
      fails++; $display("FAIL single_b2b: got valid=%b idx=%0d expected valid=1 idx=8", valid, idx);
    end
    // Reset mid-offer, between clock edges.
    #2 rst = 1'b1;
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL async_valid: got %b expected 0", valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_busy: got %b expected 0", busy); end
    tests++; if (idx !== 4'd0) begin fails++; $display("FAIL async_idx: got %0d expected 0", idx); end
    @(negedge clk);
    rst = 1'b0;
    // Bits 4 and 10: ptr=0 picks 4, a stale ptr of 9 would pick 10.
    req = 16'h0410;
    #4;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL latency_early: got %b expected 0", valid); end
    @(negedge clk);
    tests++;
    if ({valid, idx} !== {1'b1, 4'd4}) begin
      fails++; $display("FAIL ptr_after_reset: got valid=%b idx=%0d expected valid=1 idx=4", valid, idx);
    end
    req = '0;
  endtask

  task automatic test_hold_sticky();
    int e;
    do_reset();
    exp_q.delete();
    exp_q.push_back(8);
    req = 16'h0100; ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      tests++;
      if ({valid, idx} !== {1'b1, 4'd8}) begin
        fails++; $display("FAIL hold_c%0d: got valid=%b idx=%0d expected valid=1 idx=8", c, valid, idx);
      end
      if (c == 2) req = '0;
    end
    e = exp_q.pop_front();
    tests++;
    if (int'(idx) !== e) begin fails++; $display("FAIL hold_accept: got %0d expected %0d", idx, e); end
    ready = 1'b1;
    // Ready stays high while idle; it must be ignored.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (valid !== 1'b0) begin fails++; $display("FAIL hold_idle_c%0d: got valid=%b expected 0", c, valid); end
    end
    req = 16'h0201;
    @(negedge clk);
    tests++;
    if ({valid, idx} !== {1'b1, 4'd9}) begin
      fails++; $display("FAIL ptr_kept: got valid=%b idx=%0d expected valid=1 idx=9", valid, idx);
    end
    req = '0; ready = 1'b0;
  endtask

  task automatic test_rotation();
    int e;
    int cyc;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 18; k++) exp_q.push_back(k % 16);
    req = 16'hFFFF; ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (valid && ready) begin
        e = exp_q.pop_front();
        tests++;
        if (int'(idx) !== e) begin fails++; $display("FAIL rotation_idx: got %0d expected %0d", idx, e); end
      end
    end
    tests++;
    if (exp_q.size() != 0 || cyc != 18) begin
      fails++;
      $display("FAIL rotation_rate: got %0d cycles %0d left expected 18 cycles 0 left", cyc, exp_q.size());
    end
    req = '0; ready = 1'b0;
  endtask

  task automatic test_fair_wrap();
    int e;
    int cyc;
    int npop;
    do_reset();
    exp_q.delete();
    exp_q.push_back(14); exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(15);
    req = 16'h4000; ready = 1'b1;
    cyc = 0; npop = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (valid && ready) begin
        e = exp_q.pop_front();
        npop++;
        tests++;
        if (int'(idx) !== e) begin fails++; $display("FAIL wrap_idx%0d: got %0d expected %0d", npop, idx, e); end
        if (npop == 1) req = 16'h8001;
      end
    end
    tests++;
    if (exp_q.size() != 0 || cyc != 4) begin
      fails++;
      $display("FAIL wrap_rate: got %0d cycles %0d left expected 4 cycles 0 left", cyc, exp_q.size());
    end
    req = '0; ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e;
    int cyc;
    do_reset();
    exp_q.delete();
    exp_q.push_back(1); exp_q.push_back(2);
    req = 16'h0006; ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (valid && ready) begin
        e = exp_q.pop_front();
        tests++;
        if (int'(idx) !== e) begin fails++; $display("FAIL b2b_idx: got %0d expected %0d", idx, e); end
        if (exp_q.size() == 0) req = '0;
      end
    end
    tests++;
    if (exp_q.size() != 0 || cyc != 2) begin
      fails++;
      $display("FAIL b2b_rate: got %0d cycles %0d left expected 2 cycles 0 left", cyc, exp_q.size());
    end
    @(negedge clk);
    tests++;
    if ({valid, busy} !== 2'b00) begin
      fails++; $display("FAIL b2b_to_idle: got valid=%b busy=%b expected 0 0", valid, busy);
    end
    @(negedge clk);
    tests++;
    if (valid !== 1'b0) begin fails++; $display("FAIL b2b_stay_idle: got %b expected 0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_non_pow2();
    int e;
    int cyc;
    logic [15:0] dec;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 21; k++) exp_q.push_back(k % 10);
    req10 = 10'h3FF; ready10 = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (valid10 && ready10) begin
        e = exp_q.pop_front();
        dec = 16'h0001 << idx10;
        tests++;
        if (int'(idx10) !== e) begin fails++; $display("FAIL np2_idx: got %0d expected %0d", idx10, e); end
        tests++;
        if (!(int'(idx10) < 10 && $onehot(dec[9:0]))) begin
          fails++; $display("FAIL np2_decode: got idx=%0d decode=%h expected one-hot within 10 bits", idx10, dec);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0 || cyc != 21) begin
      fails++;
      $display("FAIL np2_rate: got %0d cycles %0d left expected 21 cycles 0 left", cyc, exp_q.size());
    end
    req10 = '0; ready10 = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_hold_sticky();
    test_rotation();
    test_fair_wrap();
    test_back_to_back();
    test_non_pow2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
